// File: rtl/axil_pkg.sv
// Shared constants for the AXI4-Lite register-slice wrapper: response codes
// and the bit position of each channel inside the PAYMASK slice-enable vector.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int CH_AW = 0;
    localparam int CH_W  = 1;
    localparam int CH_B  = 2;
    localparam int CH_AR = 3;
    localparam int CH_R  = 4;

endpackage

// File: rtl/axil_skid_slice.sv
// Two-entry skid register slice for one valid/ready channel.
// The output register carries the beat currently presented downstream; the skid
// register catches the one beat that can arrive in the cycle the output stalls,
// because the upstream only sees the registered ready one cycle late.
module axil_skid_slice #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         ready_q,     ready_d;
    logic         in_fire;
    logic         out_fire;

    assign in_fire  = in_valid & ready_q;
    assign out_fire = out_valid_q & out_ready;

    assign in_ready  = ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Next-state: refill the output register from skid first, else from input; park a beat in skid on stall.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || out_fire) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = in_data;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
        ready_d = !skid_valid_d;
    end

    // State registers; reset empties both entries and holds ready low until the first edge after release.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end

endmodule

// File: rtl/axil_if.sv
// AXI4-Lite pass-through / register-slice wrapper.
// Each of the five channels is either a plain wire or a skid slice, chosen by
// its bit in PAYMASK. Payload fields of a channel are packed into one vector
// so a single slice instance carries them together.
module axil_if
    import axil_pkg::*;
#(
    parameter int         N       = 4,
    parameter int         A       = 32,
    parameter logic [4:0] PAYMASK = 5'b01101
) (
    input  logic           i_clk,
    input  logic           i_rst,

    input  logic           s_awvalid,
    input  logic [A-1:0]   s_awaddr,
    output logic           s_awready,
    input  logic           s_wvalid,
    input  logic [8*N-1:0] s_wdata,
    input  logic [N-1:0]   s_wstrb,
    output logic           s_wready,
    output logic           s_bvalid,
    output logic [1:0]     s_bresp,
    input  logic           s_bready,
    input  logic           s_arvalid,
    input  logic [A-1:0]   s_araddr,
    output logic           s_arready,
    output logic           s_rvalid,
    output logic [8*N-1:0] s_rdata,
    output logic [1:0]     s_rresp,
    input  logic           s_rready,

    output logic           m_awvalid,
    output logic [A-1:0]   m_awaddr,
    input  logic           m_awready,
    output logic           m_wvalid,
    output logic [8*N-1:0] m_wdata,
    output logic [N-1:0]   m_wstrb,
    input  logic           m_wready,
    input  logic           m_bvalid,
    input  logic [1:0]     m_bresp,
    output logic           m_bready,
    output logic           m_arvalid,
    output logic [A-1:0]   m_araddr,
    input  logic           m_arready,
    input  logic           m_rvalid,
    input  logic [8*N-1:0] m_rdata,
    input  logic [1:0]     m_rresp,
    output logic           m_rready
);

    localparam int WW = 8*N + N;
    localparam int RW = 8*N + 2;

    // Write address channel, upstream to downstream.
    if (PAYMASK[CH_AW]) begin : g_aw_slice
        axil_skid_slice #(.W(A)) u_aw (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .in_valid  (s_awvalid),
            .in_data   (s_awaddr),
            .in_ready  (s_awready),
            .out_valid (m_awvalid),
            .out_data  (m_awaddr),
            .out_ready (m_awready)
        );
    end else begin : g_aw_wire
        assign m_awvalid = s_awvalid;
        assign m_awaddr  = s_awaddr;
        assign s_awready = m_awready;
    end

    // Write data channel, upstream to downstream; data and strobe travel as one payload.
    if (PAYMASK[CH_W]) begin : g_w_slice
        logic [WW-1:0] w_out;
        axil_skid_slice #(.W(WW)) u_w (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .in_valid  (s_wvalid),
            .in_data   ({s_wdata, s_wstrb}),
            .in_ready  (s_wready),
            .out_valid (m_wvalid),
            .out_data  (w_out),
            .out_ready (m_wready)
        );
        assign {m_wdata, m_wstrb} = w_out;
    end else begin : g_w_wire
        assign m_wvalid = s_wvalid;
        assign m_wdata  = s_wdata;
        assign m_wstrb  = s_wstrb;
        assign s_wready = m_wready;
    end

    // Write response channel, downstream to upstream; response code passes untouched.
    if (PAYMASK[CH_B]) begin : g_b_slice
        axil_skid_slice #(.W(2)) u_b (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .in_valid  (m_bvalid),
            .in_data   (m_bresp),
            .in_ready  (m_bready),
            .out_valid (s_bvalid),
            .out_data  (s_bresp),
            .out_ready (s_bready)
        );
    end else begin : g_b_wire
        assign s_bvalid = m_bvalid;
        assign s_bresp  = m_bresp;
        assign m_bready = s_bready;
    end

    // Read address channel, upstream to downstream.
    if (PAYMASK[CH_AR]) begin : g_ar_slice
        axil_skid_slice #(.W(A)) u_ar (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .in_valid  (s_arvalid),
            .in_data   (s_araddr),
            .in_ready  (s_arready),
            .out_valid (m_arvalid),
            .out_data  (m_araddr),
            .out_ready (m_arready)
        );
    end else begin : g_ar_wire
        assign m_arvalid = s_arvalid;
        assign m_araddr  = s_araddr;
        assign s_arready = m_arready;
    end

    // Read data channel, downstream to upstream; data and response travel as one payload.
    if (PAYMASK[CH_R]) begin : g_r_slice
        logic [RW-1:0] r_out;
        axil_skid_slice #(.W(RW)) u_r (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .in_valid  (m_rvalid),
            .in_data   ({m_rdata, m_rresp}),
            .in_ready  (m_rready),
            .out_valid (s_rvalid),
            .out_data  (r_out),
            .out_ready (s_rready)
        );
        assign {s_rdata, s_rresp} = r_out;
    end else begin : g_r_wire
        assign s_rvalid = m_rvalid;
        assign s_rdata  = m_rdata;
        assign s_rresp  = m_rresp;
        assign m_rready = s_rready;
    end

endmodule

// File: tb/tb_axil_if.sv
// Self-checking bench for axil_if with N=4, A=32, PAYMASK=5'b01101.
// Directed latency/stall/reset checks plus a scoreboard that records every
// input handshake and compares it against every output handshake.
module tb_axil_if;
    import axil_pkg::*;

    localparam int N = 4;
    localparam int A = 32;

    logic           i_clk;
    logic           i_rst;
    logic           s_awvalid, s_awready;
    logic [A-1:0]   s_awaddr;
    logic           s_wvalid, s_wready;
    logic [8*N-1:0] s_wdata;
    logic [N-1:0]   s_wstrb;
    logic           s_bvalid, s_bready;
    logic [1:0]     s_bresp;
    logic           s_arvalid, s_arready;
    logic [A-1:0]   s_araddr;
    logic           s_rvalid, s_rready;
    logic [8*N-1:0] s_rdata;
    logic [1:0]     s_rresp;
    logic           m_awvalid, m_awready;
    logic [A-1:0]   m_awaddr;
    logic           m_wvalid, m_wready;
    logic [8*N-1:0] m_wdata;
    logic [N-1:0]   m_wstrb;
    logic           m_bvalid, m_bready;
    logic [1:0]     m_bresp;
    logic           m_arvalid, m_arready;
    logic [A-1:0]   m_araddr;
    logic           m_rvalid, m_rready;
    logic [8*N-1:0] m_rdata;
    logic [1:0]     m_rresp;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [A-1:0]     awQ[$];
    logic [8*N+N-1:0] wQ[$];
    logic [1:0]       bQ[$];
    logic [A-1:0]     arQ[$];
    logic [8*N+1:0]   rQ[$];

    axil_if #(.N(N), .A(A), .PAYMASK(5'b01101)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .s_awvalid (s_awvalid),
        .s_awaddr  (s_awaddr),
        .s_awready (s_awready),
        .s_wvalid  (s_wvalid),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wready  (s_wready),
        .s_bvalid  (s_bvalid),
        .s_bresp   (s_bresp),
        .s_bready  (s_bready),
        .s_arvalid (s_arvalid),
        .s_araddr  (s_araddr),
        .s_arready (s_arready),
        .s_rvalid  (s_rvalid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rready  (s_rready),
        .m_awvalid (m_awvalid),
        .m_awaddr  (m_awaddr),
        .m_awready (m_awready),
        .m_wvalid  (m_wvalid),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wready  (m_wready),
        .m_bvalid  (m_bvalid),
        .m_bresp   (m_bresp),
        .m_bready  (m_bready),
        .m_arvalid (m_arvalid),
        .m_araddr  (m_araddr),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rready  (m_rready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic stepClock();
        @(posedge i_clk);
        #1;
    endtask

    // Scoreboard: sample handshakes mid-cycle, push inputs, pop and compare outputs; reset discards held beats.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            awQ.delete(); wQ.delete(); bQ.delete(); arQ.delete(); rQ.delete();
        end else begin
            if (s_awvalid && s_awready) awQ.push_back(s_awaddr);
            if (s_wvalid && s_wready)   wQ.push_back({s_wdata, s_wstrb});
            if (m_bvalid && m_bready)   bQ.push_back(m_bresp);
            if (s_arvalid && s_arready) arQ.push_back(s_araddr);
            if (m_rvalid && m_rready)   rQ.push_back({m_rdata, m_rresp});
            if (m_awvalid && m_awready) begin
                if (awQ.size() == 0) checkOutput("sb_aw_unexpected", 64'(m_awaddr), 64'hDEAD_0000);
                else checkOutput("sb_aw", 64'(m_awaddr), 64'(awQ.pop_front()));
            end
            if (m_wvalid && m_wready) begin
                if (wQ.size() == 0) checkOutput("sb_w_unexpected", 64'({m_wdata, m_wstrb}), 64'hDEAD_0000);
                else checkOutput("sb_w", 64'({m_wdata, m_wstrb}), 64'(wQ.pop_front()));
            end
            if (s_bvalid && s_bready) begin
                if (bQ.size() == 0) checkOutput("sb_b_unexpected", 64'(s_bresp), 64'hDEAD_0000);
                else checkOutput("sb_b", 64'(s_bresp), 64'(bQ.pop_front()));
            end
            if (m_arvalid && m_arready) begin
                if (arQ.size() == 0) checkOutput("sb_ar_unexpected", 64'(m_araddr), 64'hDEAD_0000);
                else checkOutput("sb_ar", 64'(m_araddr), 64'(arQ.pop_front()));
            end
            if (s_rvalid && s_rready) begin
                if (rQ.size() == 0) checkOutput("sb_r_unexpected", 64'({s_rdata, s_rresp}), 64'hDEAD_0000);
                else checkOutput("sb_r", 64'({s_rdata, s_rresp}), 64'(rQ.pop_front()));
            end
        end
    end

    task automatic applyStimulus();
        logic [A-1:0] arAddrs[4];
        logic awFire, wFire, arFire, bFire, rFire;
        arAddrs[0] = 32'h100; arAddrs[1] = 32'h104; arAddrs[2] = 32'h108; arAddrs[3] = 32'h10C;

        // Reset state
        #2;
        checkOutput("rst_s_awready", 64'(s_awready), 64'd0);
        checkOutput("rst_m_awvalid", 64'(m_awvalid), 64'd0);
        checkOutput("rst_m_bready",  64'(m_bready),  64'd0);
        checkOutput("rst_s_bvalid",  64'(s_bvalid),  64'd0);
        checkOutput("rst_s_arready", 64'(s_arready), 64'd0);
        checkOutput("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        checkOutput("rst_m_araddr",  64'(m_araddr),  64'd0);
        stepClock();
        stepClock();
        i_rst = 1'b1;
        #1;
        checkOutput("rel_s_awready_low", 64'(s_awready), 64'd0);
        stepClock();
        #1;
        checkOutput("rel_s_awready", 64'(s_awready), 64'd1);
        checkOutput("rel_s_arready", 64'(s_arready), 64'd1);
        checkOutput("rel_m_bready",  64'(m_bready),  64'd1);

        // Single write: AW sliced, W pass-through, B sliced
        stepClock();
        s_awvalid = 1'b1; s_awaddr = 32'h107;
        s_wvalid = 1'b1; s_wdata = 32'h111; s_wstrb = 4'hF;
        m_awready = 1'b1; m_wready = 1'b1;
        #1;
        checkOutput("wr_m_wvalid",   64'(m_wvalid),  64'd1);
        checkOutput("wr_m_wdata",    64'(m_wdata),   64'h111);
        checkOutput("wr_m_wstrb",    64'(m_wstrb),   64'hF);
        checkOutput("wr_aw_not_yet", 64'(m_awvalid), 64'd0);
        stepClock();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        #1;
        checkOutput("wr_m_awvalid", 64'(m_awvalid), 64'd1);
        checkOutput("wr_m_awaddr",  64'(m_awaddr),  64'h107);
        stepClock();
        m_bvalid = 1'b1; m_bresp = RESP_SLVERR; s_bready = 1'b1;
        #1;
        checkOutput("wr_aw_drained", 64'(m_awvalid), 64'd0);
        checkOutput("wr_b_not_yet",  64'(s_bvalid),  64'd0);
        stepClock();
        m_bvalid = 1'b0;
        #1;
        checkOutput("wr_s_bvalid", 64'(s_bvalid), 64'd1);
        checkOutput("wr_s_bresp",  64'(s_bresp),  64'(RESP_SLVERR));
        stepClock();

        // Read at 0x00C; R is a wire
        s_arvalid = 1'b1; s_araddr = 32'h00C; m_arready = 1'b1;
        stepClock();
        s_arvalid = 1'b0;
        #1;
        checkOutput("rd_m_araddr", 64'(m_araddr), 64'h00C);
        stepClock();
        m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; m_rresp = RESP_OKAY; s_rready = 1'b1;
        #1;
        checkOutput("rd_s_rvalid", 64'(s_rvalid), 64'd1);
        checkOutput("rd_s_rdata",  64'(s_rdata),  64'hDEADBEEF);
        checkOutput("rd_s_rresp",  64'(s_rresp),  64'(RESP_OKAY));
        checkOutput("rd_m_rready", 64'(m_rready), 64'd1);
        stepClock();
        m_rvalid = 1'b0;

        // Four back-to-back AR beats at full throughput
        for (int i = 0; i < 4; i++) begin
            s_arvalid = 1'b1; s_araddr = arAddrs[i];
            #1;
            checkOutput("b2b_s_arready", 64'(s_arready), 64'd1);
            if (i > 0) begin
                checkOutput("b2b_m_arvalid", 64'(m_arvalid), 64'd1);
                checkOutput("b2b_m_araddr",  64'(m_araddr),  64'(arAddrs[i-1]));
            end
            stepClock();
        end
        s_arvalid = 1'b0;
        #1;
        checkOutput("b2b_last_valid", 64'(m_arvalid), 64'd1);
        checkOutput("b2b_last_addr",  64'(m_araddr),  64'h10C);
        stepClock();
        #1;
        checkOutput("b2b_idle", 64'(m_arvalid), 64'd0);

        // AR stall: skid fills, ready drops, then drains in order
        m_arready = 1'b0;
        s_arvalid = 1'b1; s_araddr = 32'h100;
        stepClock();
        s_araddr = 32'h104;
        #1;
        checkOutput("stall_ready_first", 64'(s_arready), 64'd1);
        stepClock();
        s_arvalid = 1'b0;
        #1;
        checkOutput("stall_ready_drop", 64'(s_arready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_hold_addr",  64'(m_araddr),  64'h100);
            checkOutput("stall_hold_valid", 64'(m_arvalid), 64'd1);
            checkOutput("stall_ready_low",  64'(s_arready), 64'd0);
            stepClock();
        end
        m_arready = 1'b1;
        #1;
        checkOutput("stall_release_addr", 64'(m_araddr), 64'h100);
        stepClock();
        #1;
        checkOutput("stall_second_valid", 64'(m_arvalid), 64'd1);
        checkOutput("stall_second_addr",  64'(m_araddr),  64'h104);
        stepClock();
        #1;
        checkOutput("stall_ready_back", 64'(s_arready), 64'd1);
        checkOutput("stall_empty",      64'(m_arvalid), 64'd0);

        // All four response codes back-to-back through the B slice
        s_bready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            m_bvalid = 1'b1; m_bresp = 2'(r);
            stepClock();
        end
        m_bvalid = 1'b0;
        stepClock();
        stepClock();

        // Reset while AW slice holds 0x104
        m_awready = 1'b0;
        s_awvalid = 1'b1; s_awaddr = 32'h104;
        stepClock();
        s_awvalid = 1'b0;
        #1;
        checkOutput("rstmid_held_addr", 64'(m_awaddr), 64'h104);
        i_rst = 1'b0;
        #1;
        checkOutput("rstmid_m_awvalid", 64'(m_awvalid), 64'd0);
        checkOutput("rstmid_s_awready", 64'(s_awready), 64'd0);
        m_wready = 1'b1; s_wvalid = 1'b1; s_wdata = 32'hCAFE0001; s_wstrb = 4'h3;
        #1;
        checkOutput("rstmid_w_pass", 64'(m_wdata), 64'hCAFE0001);
        stepClock();
        s_wvalid = 1'b0;
        stepClock();
        i_rst = 1'b1;
        m_awready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            stepClock();
            #1;
            checkOutput("rstmid_no_emit", 64'(m_awvalid), 64'd0);
        end

        // Randomised traffic on all channels with random back-pressure
        awFire = 1'b0; wFire = 1'b0; arFire = 1'b0; bFire = 1'b0; rFire = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!s_awvalid || awFire) begin s_awvalid = 1'($urandom_range(0, 1)); s_awaddr = $urandom; end
            if (!s_wvalid || wFire) begin s_wvalid = 1'($urandom_range(0, 1)); s_wdata = $urandom; s_wstrb = 4'($urandom); end
            if (!s_arvalid || arFire) begin s_arvalid = 1'($urandom_range(0, 1)); s_araddr = $urandom; end
            if (!m_bvalid || bFire) begin m_bvalid = 1'($urandom_range(0, 1)); m_bresp = 2'($urandom); end
            if (!m_rvalid || rFire) begin m_rvalid = 1'($urandom_range(0, 1)); m_rdata = $urandom; m_rresp = 2'($urandom); end
            m_awready = 1'($urandom_range(0, 1));
            m_wready  = 1'($urandom_range(0, 1));
            m_arready = 1'($urandom_range(0, 1));
            s_bready  = 1'($urandom_range(0, 1));
            s_rready  = 1'($urandom_range(0, 1));
            #1;
            awFire = s_awvalid && s_awready;
            wFire  = s_wvalid && s_wready;
            arFire = s_arvalid && s_arready;
            bFire  = m_bvalid && m_bready;
            rFire  = m_rvalid && m_rready;
            stepClock();
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1; s_bready = 1'b1; s_rready = 1'b1;
        repeat (6) stepClock();
        checkOutput("drain_aw", 64'(awQ.size()), 64'd0);
        checkOutput("drain_w",  64'(wQ.size()),  64'd0);
        checkOutput("drain_b",  64'(bQ.size()),  64'd0);
        checkOutput("drain_ar", 64'(arQ.size()), 64'd0);
        checkOutput("drain_r",  64'(rQ.size()),  64'd0);
    endtask

    initial begin
        i_rst = 1'b0;
        s_awvalid = 1'b0; s_awaddr = '0;
        s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
        s_bready = 1'b0;
        s_arvalid = 1'b0; s_araddr = '0;
        s_rready = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_bvalid = 1'b0; m_bresp = '0;
        m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
